shiftreg_stream: RTL and testbench
==================================

// Module: shiftreg_stream
// PURPOSE
//  Parametrised parallel-to-serial streamer; next generation of the team's PISO shift register.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits LANES bits per beat.
//  Supports MSB- or LSB-first order, downstream backpressure and o_last framing.
//  A one-entry holding buffer lets consecutive words stream with no idle beat between them.
//  Sits between word-oriented producers and narrow serial links or pins.
// PARAMETERS
//  WIDTH      8  word width in bits; >=2; WIDTH % LANES == 0
//  LANES      1  bits emitted per beat; 1..WIDTH
//  MSB_FIRST  1  1: emit the MS lane first; 0: emit the LS lane first
// PORTS
//  clk        in   1            single clock; all logic acts on posedge
//  rst        in   1            asynchronous reset, active-high
//  i_wr_data  in   WIDTH        parallel word from the producer
//  i_wr_valid in   1            producer has a word
//  o_wr_ready out  1            block can take a word (= holding buffer empty)
//  o_data     out  LANES        serial beat; bit order inside a lane matches the word's bit order
//  o_valid    out  1            o_data/o_last are valid
//  i_ready    in   1            consumer takes the beat
//  o_last     out  1            current beat is the final beat of its word
//  o_busy     out  1            a word is shifting or held
// BEHAVIOUR
//  Constants: BEATS = WIDTH/LANES; CNT_W = max(1,$clog2(BEATS)).
//  Reset (async, any cycle, including mid-word):
//   - Drops the word being shifted and the held word; no partial word resumes.
//   - Outputs: o_valid=0, o_data=0, o_last=0, o_busy=0, o_wr_ready=1.
//  Upstream accept:
//   - Accept = i_wr_valid & o_wr_ready.
//   - o_wr_ready is a register-derived signal; it never depends combinationally on i_ready.
//  States:
//   - IDLE: shifter empty; o_valid=0.
//   - SHIFT: shifter loaded; o_valid=1.
//  Beat handshake:
//   - Beat fires = o_valid & i_ready.
//   - o_data and o_last hold steady while o_valid=1 & i_ready=0.
//   - Each fired beat shifts the register by LANES and increments beat counter cnt.
//  o_last = o_valid & (cnt == BEATS-1).
//  Load rules, evaluated each edge:
//   - IDLE & accept: word goes straight into the shifter; SHIFT next cycle (latency 1 from accept to first beat).
//   - Last beat fires & holding buffer full: load held word into the shifter, cnt=0, stay in SHIFT; buffer empties.
//   - Last beat fires & buffer empty & accept: load the incoming word directly (bypass); no bubble.
//   - Last beat fires & nothing pending: go to IDLE.
//   - Otherwise, accept while in SHIFT: word goes to the holding buffer; o_wr_ready=0 until it moves.
//  Throughput: 1 beat per cycle sustained when i_ready=1; words are contiguous, never reordered.
//  Emission order:
//   - MSB_FIRST=1: beat k = word[WIDTH-1-k*LANES -: LANES].
//   - MSB_FIRST=0: beat k = word[k*LANES +: LANES].
//  Vacated shifter bits fill with 0. o_data=0 whenever o_valid=0.
//  o_busy = (state==SHIFT) | hold_full.
//  Degenerate case LANES==WIDTH: BEATS=1; every beat is last; counter unused.
// STRUCTURE
//  Package shiftreg_pkg: typedef enum {ST_IDLE, ST_SHIFT} state_t; function clog2_min1.
//  One sub-module, shiftreg_hold: 1-entry WIDTH-bit holding buffer.
//   - Ports: clk, rst, i_push, i_data, i_pop, o_full, o_data.
//   - Push and pop in the same cycle while full leaves the entry full with the new data.
//  Top level contains the FSM, beat counter, shifter and load mux.
// TESTING
//  1. WIDTH=8,LANES=1,MSB_FIRST=1: push 0xA5, i_ready=1 -> o_data 1,0,1,0,0,1,0,1 over 8 cycles; o_last only on the 8th.
//  2. MSB_FIRST=0, push 0xA5 -> 1,0,1,0,0,1,0,1 reversed per LSB order: 1,0,1,0,0,1,0,1 (LSB->MSB of 0xA5); check with 0x01 -> 1 then seven 0s.
//  3. Back-to-back: push 0xFF then 0x00 at consecutive cycles -> 16 contiguous valid beats (8 ones, 8 zeros); o_wr_ready=0 while 0x00 is held; no bubble.
//  4. Backpressure: hold i_ready=0 for 5 cycles mid-word -> o_data/o_last stable; no beat lost or duplicated; total 8 beats.
//  5. LANES=2,WIDTH=8,MSB_FIRST=1: push 0xB4 -> beats 2'b10,2'b11,2'b01,2'b00; o_last on the 4th.
//  6. Assert rst after 3 beats of 0xA5 with a word held -> same cycle o_valid=0, o_busy=0, o_wr_ready=1; next push 0x3C emits fully and correctly.

Source files
------------

// File: rtl/shiftreg_stream_pkg.sv
// Shared types and helpers for the shiftreg_stream parallel-to-serial streamer.
//   state_t     : streamer FSM state (IDLE = shifter empty, SHIFT = shifter loaded)
//   clog2_min1  : ceil(log2(value)), but never less than 1 so counters keep a legal width
package shiftreg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2_min1(input int value);
        int result;
        if (value <= 1) begin
            result = 1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/shiftreg_stream_hold.sv
// One-entry holding buffer that parks the next word while the shifter is busy.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data into the entry (wins over i_pop, so push+pop keeps it full)
//   i_data   : word to store
//   i_pop    : release the entry
//   o_full   : entry holds a word
//   o_data   : stored word (zero when empty)
module shiftreg_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             full_r;
    logic [WIDTH-1:0] data_r;

    // Entry storage and occupancy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (i_push) begin
            full_r <= 1'b1;
            data_r <= i_data;
        end else if (i_pop) begin
            full_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else begin
            full_r <= full_r;
            data_r <= data_r;
        end
    end

    assign o_full = full_r;
    assign o_data = data_r;

endmodule

// File: rtl/shiftreg_stream.sv
// Parallel-to-serial streamer: takes WIDTH-bit words on a valid/ready handshake
// and emits LANES bits per beat, MSB- or LSB-lane first, with o_last framing.
// A one-entry holding buffer lets the next word follow the current one with no
// idle beat.
//   clk, rst   : clock, asynchronous active-high reset
//   i_wr_data  : producer word          i_wr_valid : producer has a word
//   o_wr_ready : holding buffer empty (register-derived, independent of i_ready)
//   o_data     : current beat (0 when o_valid=0)
//   o_valid    : beat valid             i_ready    : consumer takes the beat
//   o_last     : final beat of a word   o_busy     : a word is shifting or held
import shiftreg_pkg::*;

module shiftreg_stream #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [LANES-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy
);

    localparam int               BEATS    = WIDTH / LANES;
    localparam int               CNT_W    = clog2_min1(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   shift_r;

    logic               hold_full_s;
    logic [WIDTH-1:0]   hold_data_s;
    logic               accept_s;
    logic               fire_s;
    logic               last_fire_s;
    logic               hold_push_s;
    logic               hold_pop_s;
    logic [LANES-1:0]   lane_s;
    logic [WIDTH-1:0]   shift_next_s;

    // Handshake decode. A word only lands in the holding buffer when the
    // shifter is busy and is not about to free up this cycle; otherwise it
    // goes straight into the shifter (IDLE load or last-beat bypass).
    always_comb begin
        accept_s    = i_wr_valid & ~hold_full_s;
        fire_s      = (state_r == ST_SHIFT) & i_ready;
        last_fire_s = fire_s & (cnt_r == CNT_LAST);
        hold_push_s = accept_s & (state_r == ST_SHIFT) & ~last_fire_s;
        hold_pop_s  = last_fire_s & hold_full_s;
    end

    // Output lane selection and shift direction; vacated bits fill with 0.
    always_comb begin
        if (MSB_FIRST) begin
            lane_s       = shift_r[WIDTH-1 -: LANES];
            shift_next_s = shift_r << LANES;
        end else begin
            lane_s       = shift_r[LANES-1:0];
            shift_next_s = shift_r >> LANES;
        end
    end

    shiftreg_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_push (hold_push_s),
        .i_data (i_wr_data),
        .i_pop  (hold_pop_s),
        .o_full (hold_full_s),
        .o_data (hold_data_s)
    );

    // FSM, beat counter, shifter and load mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r <= i_wr_data;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_SHIFT;
                    end else begin
                        shift_r <= shift_r;
                        cnt_r   <= cnt_r;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (last_fire_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (hold_full_s) begin
                            shift_r <= hold_data_s;
                            state_r <= ST_SHIFT;
                        end else if (accept_s) begin
                            shift_r <= i_wr_data;
                            state_r <= ST_SHIFT;
                        end else begin
                            shift_r <= {WIDTH{1'b0}};
                            state_r <= ST_IDLE;
                        end
                    end else if (fire_s) begin
                        shift_r <= shift_next_s;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_SHIFT;
                    end else begin
                        shift_r <= shift_r;
                        cnt_r   <= cnt_r;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    shift_r <= {WIDTH{1'b0}};
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from registers only.
    always_comb begin
        o_valid    = (state_r == ST_SHIFT);
        o_data     = o_valid ? lane_s : {LANES{1'b0}};
        o_last     = o_valid & (cnt_r == CNT_LAST);
        o_busy     = o_valid | hold_full_s;
        o_wr_ready = ~hold_full_s;
    end

endmodule

// File: tb/tb_shiftreg_stream.sv
// Self-checking bench for shiftreg_stream. Three instances (8/1/MSB, 8/1/LSB,
// 8/2/MSB) run directed and random traffic in parallel. Each keeps a queue of
// pending beats as its reference: a word adds BEATS entries computed from the
// emission-order formula, a fired beat removes one.
module tb_shiftreg_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int         L     = (g == 2) ? 2 : 1;
        localparam bit         M     = (g != 1);
        localparam int         BEATS = 8 / L;
        localparam logic [7:0] D1    = (g == 0) ? 8'hA5 : ((g == 1) ? 8'h01 : 8'hB4);

        logic         rst;
        logic         wvalid;
        logic         wready;
        logic         ovalid;
        logic         rdy;
        logic         olast;
        logic         obusy;
        logic [7:0]   wdata;
        logic [L-1:0] odata;
        bit           done = 1'b0;

        int unsigned  exp_q[$];
        logic [7:0]   col    = 8'h00;
        int           nbeats = 0;
        int           nlast  = 0;

        shiftreg_stream #(
            .WIDTH     (8),
            .LANES     (L),
            .MSB_FIRST (M)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .i_wr_data  (wdata),
            .i_wr_valid (wvalid),
            .o_wr_ready (wready),
            .o_data     (odata),
            .o_valid    (ovalid),
            .i_ready    (rdy),
            .o_last     (olast),
            .o_busy     (obusy)
        );

        // Reference: pending-beat queue. Entry = {last, lane value}.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                bit fire;
                bit acc;
                fire = (exp_q.size() > 0) && rdy;
                acc  = wvalid && (exp_q.size() <= BEATS);
                if (fire) void'(exp_q.pop_front());
                if (acc) begin
                    for (int k = 0; k < BEATS; k++) begin
                        int          sh;
                        int unsigned b;
                        sh = M ? (8 - (k + 1) * L) : (k * L);
                        b  = (int'(wdata) >> sh) & ((1 << L) - 1);
                        exp_q.push_back(b | ((k == BEATS - 1) ? 32'd256 : 32'd0));
                    end
                end
            end
        end

        // Compare every output against the reference each cycle.
        always @(negedge clk) begin
            int unsigned hd;
            hd = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
            check_eq($sformatf("i%0d.valid", g), ovalid, exp_q.size() > 0);
            check_eq($sformatf("i%0d.data", g), int'(odata), hd & 32'hFF);
            check_eq($sformatf("i%0d.last", g), olast, hd >> 8);
            check_eq($sformatf("i%0d.wr_ready", g), wready, exp_q.size() <= BEATS);
            check_eq($sformatf("i%0d.busy", g), obusy, exp_q.size() > 0);
        end

        // Reassemble fired beats into the most recent word.
        always @(negedge clk) begin
            #2;
            if (!rst && ovalid && rdy) begin
                if (M) col <= (col << L) | 8'(odata);
                else   col <= (col >> L) | 8'(int'(odata) << (8 - L));
                nbeats <= nbeats + 1;
                nlast  <= nlast + int'(olast);
            end
        end

        task automatic step();
            @(negedge clk);
            #1;
        endtask

        task automatic push(input logic [7:0] w);
            wdata  = w;
            wvalid = 1'b1;
            for (int i = 0; i < 100 && !wready; i++) step();
            check_eq($sformatf("i%0d.push_timeout", g), wready, 1);
            step();
            wvalid = 1'b0;
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 200 && (obusy || exp_q.size() > 0); i++) step();
            check_eq($sformatf("i%0d.idle_timeout", g), obusy, 0);
        endtask

        initial begin
            int  b0;
            int  l0;
            bit  took;
            rst    = 1'b1;
            wvalid = 1'b0;
            wdata  = 8'h00;
            rdy    = 1'b1;
            step();
            step();
            rst = 1'b0;

            // Single word at full rate.
            b0 = nbeats; l0 = nlast;
            push(D1);
            wait_idle();
            check_eq($sformatf("i%0d.word1", g), col, D1);
            check_eq($sformatf("i%0d.word1_beats", g), nbeats - b0, BEATS);
            check_eq($sformatf("i%0d.word1_lasts", g), nlast - l0, 1);

            // Back-to-back words; second one is parked in the holding buffer.
            b0 = nbeats; l0 = nlast;
            push(8'hFF);
            push(8'h00);
            check_eq($sformatf("i%0d.held_not_ready", g), wready, 0);
            wait_idle();
            check_eq($sformatf("i%0d.b2b_word", g), col, 8'h00);
            check_eq($sformatf("i%0d.b2b_beats", g), nbeats - b0, 2 * BEATS);
            check_eq($sformatf("i%0d.b2b_lasts", g), nlast - l0, 2);

            // Backpressure mid-word.
            b0 = nbeats;
            push(8'h96);
            step(); step(); step();
            rdy = 1'b0;
            repeat (5) step();
            rdy = 1'b1;
            wait_idle();
            check_eq($sformatf("i%0d.bp_word", g), col, 8'h96);
            check_eq($sformatf("i%0d.bp_beats", g), nbeats - b0, BEATS);

            // Reset mid-word with a word held, then a clean word.
            push(8'hA5);
            push(8'h5A);
            step(); step();
            rst = 1'b1;
            #1;
            check_eq($sformatf("i%0d.rst_valid", g), ovalid, 0);
            check_eq($sformatf("i%0d.rst_busy", g), obusy, 0);
            check_eq($sformatf("i%0d.rst_ready", g), wready, 1);
            check_eq($sformatf("i%0d.rst_data", g), int'(odata), 0);
            step();
            rst = 1'b0;
            b0 = nbeats;
            push(8'h3C);
            wait_idle();
            check_eq($sformatf("i%0d.post_rst_word", g), col, 8'h3C);
            check_eq($sformatf("i%0d.post_rst_beats", g), nbeats - b0, BEATS);

            // Random traffic with random backpressure.
            took = 1'b0;
            for (int c = 0; c < 400; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                if (!wvalid || took) begin
                    wvalid = ($urandom_range(0, 1) == 1);
                    wdata  = 8'($urandom);
                end
                took = wvalid && wready;
                step();
            end
            wvalid = 1'b0;
            rdy    = 1'b1;
            wait_idle();
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(g_inst[0].done && g_inst[1].done && g_inst[2].done); i++)
            @(negedge clk);
        check_eq("all_done", g_inst[0].done && g_inst[1].done && g_inst[2].done, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
